alu_issue_ctrl: RTL

- Initiator side of the CPU ALU interface.
- Accepts ALU requests from the decoder over a valid/ready handshake and drives the combinational ALU's operand, op and cpu_flags inputs.
- Captures the ALU result and flag byte, returns the result over a valid/ready response channel, and owns the architectural flags register.
- Also evaluates branch condition codes from that flags register.

---
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the CPU ALU interface: issues decoder requests to the ALU,
// captures results and owns the flags register. Option: ALU_ISSUE_CTRL_BACK2BACK_EN.
module alu_issue_ctrl #(
    parameter logic [7:0]  FLAGS_RST = 8'h00,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_wb,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_cpu_flags,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [7:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_wb,
    output logic [7:0]        flags,
    input  logic              flags_wr,
    input  logic [7:0]        flags_wdata,
    input  logic [3:0]        cond_sel,
    output logic              cond_true,
    output logic              busy
);

    localparam logic [7:0] FLAGS_MASK = 8'h3F;
    localparam logic [3:0] OP_SHR     = 4'd12;
    localparam logic [3:0] OP_SHL     = 4'd13;
    localparam logic [3:0] OP_SAR     = 4'd14;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic [3:0]        hold_op;
    logic              hold_wb;
    logic              accept;
    logic              zero_shift;

    assign alu_a         = hold_a;
    assign alu_b         = hold_b;
    assign alu_op        = hold_op;
    assign alu_cpu_flags = flags;
    assign busy          = (state != IDLE);
    assign accept        = req_valid && req_ready;

    // A shift by zero passes a through untouched and leaves the flags alone.
    assign zero_shift = ((hold_op == OP_SHR) || (hold_op == OP_SHL) || (hold_op == OP_SAR))
                        && (hold_b == '0);

`ifdef ALU_ISSUE_CTRL_BACK2BACK_EN
    assign req_ready = !flags_wr && ((state == IDLE) || ((state == RESP) && rsp_ready));
`else
    assign req_ready = !flags_wr && (state == IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flags     <= FLAGS_RST & FLAGS_MASK;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_wb    <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_op   <= '0;
            hold_wb   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flags_wr) begin
                        flags <= flags_wdata & FLAGS_MASK;
                    end else if (accept) begin
                        hold_a  <= req_a;
                        hold_b  <= req_b;
                        hold_op <= req_op;
                        hold_wb <= req_wb;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_wb    <= hold_wb;
                    if (zero_shift) begin
                        rsp_data <= hold_a;
                    end else begin
                        rsp_data <= alu_c;
                        flags    <= alu_flags & FLAGS_MASK;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_ISSUE_CTRL_BACK2BACK_EN
                        if (accept) begin
                            hold_a  <= req_a;
                            hold_b  <= req_b;
                            hold_op <= req_op;
                            hold_wb <= req_wb;
                            state   <= EXEC;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Branch condition evaluation from the architectural flags.
    always_comb begin
        logic s, z, v, p, c;
        s = flags[5];
        z = flags[4];
        v = flags[2];
        p = flags[1];
        c = flags[0];
        cond_true = 1'b0;
        case (cond_sel)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = z;
            4'd2:    cond_true = !z;
            4'd3:    cond_true = c;
            4'd4:    cond_true = !c;
            4'd5:    cond_true = s;
            4'd6:    cond_true = !s;
            4'd7:    cond_true = v;
            4'd8:    cond_true = !v;
            4'd9:    cond_true = p;
            4'd10:   cond_true = !p;
            4'd11:   cond_true = !c && !z;
            4'd12:   cond_true = c || z;
            4'd13:   cond_true = !z && (s == v);
            4'd14:   cond_true = (s == v);
            default: cond_true = (s != v);
        endcase
    end

endmodule
